counter_job_scheduler: RTL and testbench



---
 rtl/counter_job_scheduler.sv | 176 +++++++++++++++++
 tb/tb_counter_job_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/counter_job_scheduler.sv
// counter_job_scheduler: round-robin sharing of one up/down counter between
// NUM_REQ requesters. A granted job latches its direction, optional preload
// and step count, runs one action per cycle, then pulses done to its owner.
module counter_job_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int COUNTER_WIDTH = 16,
  parameter int STEP_WIDTH    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_dir,
  input  logic [NUM_REQ-1:0]               req_load,
  input  logic [NUM_REQ*COUNTER_WIDTH-1:0] req_load_value,
  input  logic [NUM_REQ*STEP_WIDTH-1:0]    req_steps,
  input  logic                             abort,
  output logic [NUM_REQ-1:0]               grant,
  output logic                             busy,
  output logic [NUM_REQ-1:0]               done,
  output logic [COUNTER_WIDTH-1:0]         done_value,
  output logic                             done_wrap,
  output logic                             done_aborted,
  output logic [COUNTER_WIDTH-1:0]         counter_value
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [STEP_WIDTH-1:0]    STEP_ONE = STEP_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_d;
  logic [IDX_W-1:0]         rr_ptr, rr_ptr_d, owner, owner_d;
  logic                     dir_q, dir_d, load_q, load_d, wrap_q, wrap_d;
  logic [COUNTER_WIDTH-1:0] load_val_q, load_val_d, cnt_d;
  logic [STEP_WIDTH-1:0]    rem_q, rem_d;
  logic [NUM_REQ-1:0]       grant_d, done_d;
  logic                     busy_d, done_wrap_d, done_aborted_d;
  logic [COUNTER_WIDTH-1:0] done_value_d;

  logic                     win_found;
  logic [IDX_W-1:0]         win, cand;
  logic [COUNTER_WIDTH-1:0] step_val, fin_val;
  logic                     step_wrap, finish, aborted;

  // Round-robin pick: scan downward so the candidate closest after rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = rr_ptr + IDX_W'(k);
      if (req[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  // One counter step in the latched direction, flagging MAX->0 / 0->MAX.
  always_comb begin
    if (dir_q) begin
      step_val  = counter_value - CNT_ONE;
      step_wrap = (counter_value == '0);
    end else begin
      step_val  = counter_value + CNT_ONE;
      step_wrap = &counter_value;
    end
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d        = state;
    rr_ptr_d       = rr_ptr;
    owner_d        = owner;
    dir_d          = dir_q;
    load_d         = load_q;
    load_val_d     = load_val_q;
    rem_d          = rem_q;
    wrap_d         = wrap_q;
    cnt_d          = counter_value;
    grant_d        = grant;
    busy_d         = busy;
    done_d         = '0;
    done_value_d   = done_value;
    done_wrap_d    = done_wrap;
    done_aborted_d = done_aborted;
    finish         = 1'b0;
    aborted        = 1'b0;
    fin_val        = counter_value;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_d          = RUN;
          owner_d          = win;
          grant_d          = '0;
          grant_d[win]     = 1'b1;
          busy_d           = 1'b1;
          dir_d            = req_dir[win];
          load_d           = req_load[win];
          load_val_d       = req_load_value[win*COUNTER_WIDTH +: COUNTER_WIDTH];
          rem_d            = req_steps[win*STEP_WIDTH +: STEP_WIDTH];
          wrap_d           = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          finish  = 1'b1;
          aborted = 1'b1;
        end else if (load_q) begin
          // Preload occupies its own edge and never counts as a step.
          cnt_d   = load_val_q;
          load_d  = 1'b0;
          fin_val = load_val_q;
          finish  = (rem_q == '0);
        end else if (rem_q != '0) begin
          cnt_d   = step_val;
          rem_d   = rem_q - STEP_ONE;
          wrap_d  = wrap_q | step_wrap;
          fin_val = step_val;
          finish  = (rem_q == STEP_ONE);
        end else begin
          finish  = 1'b1;
        end
        if (finish) begin
          done_d[owner]  = 1'b1;
          done_value_d   = fin_val;
          done_wrap_d    = wrap_d;
          done_aborted_d = aborted;
          grant_d        = '0;
          busy_d         = 1'b0;
          rr_ptr_d       = owner;
          state_d        = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, job context and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= IDX_W'(NUM_REQ - 1);
      owner         <= '0;
      dir_q         <= 1'b0;
      load_q        <= 1'b0;
      load_val_q    <= '0;
      rem_q         <= '0;
      wrap_q        <= 1'b0;
      counter_value <= '0;
      grant         <= '0;
      busy          <= 1'b0;
      done          <= '0;
      done_value    <= '0;
      done_wrap     <= 1'b0;
      done_aborted  <= 1'b0;
    end else begin
      state         <= state_d;
      rr_ptr        <= rr_ptr_d;
      owner         <= owner_d;
      dir_q         <= dir_d;
      load_q        <= load_d;
      load_val_q    <= load_val_d;
      rem_q         <= rem_d;
      wrap_q        <= wrap_d;
      counter_value <= cnt_d;
      grant         <= grant_d;
      busy          <= busy_d;
      done          <= done_d;
      done_value    <= done_value_d;
      done_wrap     <= done_wrap_d;
      done_aborted  <= done_aborted_d;
    end
  end
endmodule

// File: tb/tb_counter_job_scheduler.sv
// Directed bench for counter_job_scheduler with hand-computed expectations.
module tb_counter_job_scheduler;
  localparam int NR = 4, CW = 16, SW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req = '0, req_dir = '0, req_load = '0;
  logic [NR*CW-1:0]  req_load_value = '0;
  logic [NR*SW-1:0]  req_steps = '0;
  logic              abort = 1'b0;
  logic [NR-1:0]     grant, done;
  logic              busy, done_wrap, done_aborted;
  logic [CW-1:0]     done_value, counter_value;

  int vectors = 0, miscompares = 0;

  counter_job_scheduler #(.NUM_REQ(NR), .COUNTER_WIDTH(CW), .STEP_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dir(req_dir), .req_load(req_load),
    .req_load_value(req_load_value), .req_steps(req_steps), .abort(abort),
    .grant(grant), .busy(busy), .done(done), .done_value(done_value),
    .done_wrap(done_wrap), .done_aborted(done_aborted), .counter_value(counter_value)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setjob(input int i, input logic dir, input logic ld,
                        input logic [CW-1:0] lv, input logic [SW-1:0] st);
    req_dir[i]               = dir;
    req_load[i]              = ld;
    req_load_value[i*CW +: CW] = lv;
    req_steps[i*SW +: SW]    = st;
  endtask

  initial begin
    logic [NR-1:0] rr_seq [5];
    rr_seq = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

    // Reset state
    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", counter_value, 0);
    chk("rst_dval", done_value, 0);
    #2 rst = 1'b0;

    // Req0 up 5 steps; inputs changed mid-run must be ignored
    setjob(0, 1'b0, 1'b0, 16'h0, 8'd5);
    req[0] = 1'b1;
    tick();
    chk("j1_grant", grant, 4'b0001);
    chk("j1_busy", busy, 1);
    chk("j1_cnt0", counter_value, 0);
    req[0] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 2) setjob(0, 1'b1, 1'b1, 16'h7777, 8'd0);
      chk("j1_cnt", counter_value, i);
      chk("j1_grant_run", grant, (i < 5) ? 4'b0001 : 4'b0000);
      chk("j1_done", done, (i < 5) ? 4'b0000 : 4'b0001);
    end
    chk("j1_dval", done_value, 5);
    chk("j1_wrap", done_wrap, 0);
    chk("j1_busy_end", busy, 0);
    tick();
    chk("j1_done_clr", done, 0);

    // Req1 load FFFE up 3 -> FFFE FFFF 0000 0001, wraps
    setjob(1, 1'b0, 1'b1, 16'hFFFE, 8'd3);
    req[1] = 1'b1;
    tick();
    chk("j2_grant", grant, 4'b0010);
    req[1] = 1'b0;
    tick(); chk("j2_load", counter_value, 16'hFFFE);
    tick(); chk("j2_c1", counter_value, 16'hFFFF);
    tick(); chk("j2_c2", counter_value, 16'h0000);
    chk("j2_nodone", done, 0);
    tick(); chk("j2_c3", counter_value, 16'h0001);
    chk("j2_done", done, 4'b0010);
    chk("j2_dval", done_value, 16'h0001);
    chk("j2_wrap", done_wrap, 1);
    tick();

    // All four requesting, 1 step each; last owner was 1 so order starts at 2
    for (int i = 0; i < NR; i++) setjob(i, 1'b0, 1'b0, 16'h0, 8'd1);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick(); chk("rr_grant", grant, rr_seq[j]);
      if (j == 4) req = '0;
      tick(); chk("rr_done", done, rr_seq[j]);
      chk("rr_grant_off", grant, 0);
      tick(); chk("rr_idle", grant, 0);
    end
    chk("rr_cnt", counter_value, 6);

    // Req3 load 0 with steps 0: done on load edge
    setjob(3, 1'b0, 1'b1, 16'h0, 8'd0);
    req[3] = 1'b1;
    tick(); chk("ld0_grant", grant, 4'b1000);
    req[3] = 1'b0;
    tick(); chk("ld0_cnt", counter_value, 0);
    chk("ld0_done", done, 4'b1000);
    chk("ld0_wrap", done_wrap, 0);
    tick();

    // Req2 down 2 from 0 -> FFFF, FFFE, wrap
    setjob(2, 1'b1, 1'b0, 16'h0, 8'd2);
    req[2] = 1'b1;
    tick(); chk("dn_grant", grant, 4'b0100);
    req[2] = 1'b0;
    tick(); chk("dn_c1", counter_value, 16'hFFFF);
    tick(); chk("dn_c2", counter_value, 16'hFFFE);
    chk("dn_done", done, 4'b0100);
    chk("dn_dval", done_value, 16'hFFFE);
    chk("dn_wrap", done_wrap, 1);
    tick();

    // Abort while idle is ignored
    abort = 1'b1;
    tick(); chk("ab_idle_done", done, 0);
    abort = 1'b0;

    // Req3 load 0, up 10, abort on the edge after counter reaches 2
    setjob(3, 1'b0, 1'b1, 16'h0, 8'd10);
    req[3] = 1'b1;
    tick(); chk("ab_grant", grant, 4'b1000);
    req[3] = 1'b0;
    tick(); chk("ab_c0", counter_value, 0);
    tick(); chk("ab_c1", counter_value, 1);
    tick(); chk("ab_c2", counter_value, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_cnt", counter_value, 2);
    chk("ab_done", done, 4'b1000);
    chk("ab_flag", done_aborted, 1);
    chk("ab_dval", done_value, 2);
    chk("ab_busy", busy, 0);
    tick();

    // Load 0x1234 (steps 0), then a steps=0 no-load job leaves it alone
    setjob(1, 1'b0, 1'b1, 16'h1234, 8'd0);
    req[1] = 1'b1;
    tick(); req[1] = 1'b0;
    tick(); chk("z_ld", counter_value, 16'h1234);
    tick();
    setjob(0, 1'b0, 1'b0, 16'h0, 8'd0);
    req[0] = 1'b1;
    tick(); chk("z_grant", grant, 4'b0001);
    req[0] = 1'b0;
    tick(); chk("z_done", done, 4'b0001);
    chk("z_dval", done_value, 16'h1234);
    chk("z_cnt", counter_value, 16'h1234);
    chk("z_wrap", done_wrap, 0);
    chk("z_ab", done_aborted, 0);
    tick();

    // Reset mid-job, then requester 0 wins first again
    setjob(1, 1'b0, 1'b0, 16'h0, 8'd10);
    req[1] = 1'b1;
    tick(); chk("mr_grant", grant, 4'b0010);
    req[1] = 1'b0;
    tick(); chk("mr_c1", counter_value, 16'h1235);
    #2 rst = 1'b1;
    #1;
    chk("mr_grant0", grant, 0);
    chk("mr_busy0", busy, 0);
    chk("mr_cnt0", counter_value, 0);
    chk("mr_done0", done, 0);
    #2 rst = 1'b0;
    for (int i = 0; i < NR; i++) setjob(i, 1'b0, 1'b0, 16'h0, 8'd1);
    req = 4'b1111;
    tick(); chk("mr_first", grant, 4'b0001);
    req = '0;
    tick(); chk("mr_done", done, 4'b0001);
    chk("mr_dval", done_value, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
